// File: rtl/cim_pkg.sv
// Shared types and sizing for the CIM macro controller.
package cim_pkg;

    localparam int unsigned ROW_WORDS = 2;
    localparam int unsigned ROW_STEP  = 8;
    localparam int unsigned NUM_OUT   = 8;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned LEN_W     = 8;
    localparam int unsigned OREG_W    = 4;
    localparam int unsigned IDX_W     = $clog2(NUM_OUT);
    localparam int unsigned WCNT_W    = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        COMPUTE,
        RD_SET,
        RD_CAP,
        RD_OUT,
        CLEAR
    } state_e;

    // Registered drive toward the macro; the per-word MAC strobe is overlaid in cim_ctrl.
    typedef struct packed {
        logic              cs;
        logic              write;
        logic              cim;
        logic              reset_output;
        logic [OREG_W-1:0] output_reg;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] input_data;
    } cim_drive_t;

endpackage

// File: rtl/cim_res_buf.sv
// Single-entry result holding register: loaded from the macro, held until the consumer takes it.
module cim_res_buf
    import cim_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              res_ready,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              fire_c
);

    assign fire_c = res_valid & res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (load) begin
            res_valid <= 1'b1;
            res_data  <= load_data;
        end else if (fire_c) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cim_ctrl.sv
// Job sequencer for a compute-in-memory macro: weight writes, row-wise MAC streaming,
// per-register readout and optional accumulator clear.
module cim_ctrl
    import cim_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_addr,
    input  logic [LEN_W-1:0]  job_len,
    input  logic              job_clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [IDX_W-1:0]  res_idx,
    output logic              res_last,
    output logic              busy,
    output logic              cim_cs,
    output logic              cim_write,
    output logic              cim_cim,
    output logic              cim_partial_sum,
    output logic              cim_reset_output,
    output logic [OREG_W-1:0] cim_output_reg,
    output logic [ADDR_W-1:0] cim_address,
    output logic [DATA_W-1:0] cim_input_data,
    output logic              cim_debug,
    input  logic [DATA_W-1:0] cim_result
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]  row_addr_q, row_addr_d;
    logic               clear_q, clear_d;
    cim_drive_t         drv_q, drv_d;
    logic               wr_ready_d, job_ready_d, in_ready_d, busy_d, res_last_d;
    logic               wr_fire, job_fire, in_fire, res_fire;

    // A write request shadows a job request offered in the same cycle.
    assign wr_fire  = wr_valid & wr_ready;
    assign job_fire = job_valid & job_ready & ~wr_valid;
    assign in_fire  = in_valid & in_ready;

    cim_res_buf u_res_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (state_q == RD_CAP),
        .load_data (cim_result),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .fire_c    (res_fire)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        row_addr_d = row_addr_q;
        clear_d    = clear_q;
        drv_d      = '0;

        case (state_q)
            IDLE: begin
                if (wr_fire) begin
                    state_d = WRITE;
                end else if (job_fire) begin
                    row_addr_d = job_addr;
                    len_d      = job_len;
                    clear_d    = job_clear;
                    cnt_d      = '0;
                    wcnt_d     = '0;
                    idx_d      = '0;
                    state_d    = (job_len != '0) ? COMPUTE : RD_SET;
                end
            end
            WRITE: state_d = IDLE;
            COMPUTE: begin
                if (in_fire) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (wcnt_q == WCNT_W'(ROW_WORDS - 1)) begin
                        wcnt_d     = '0;
                        row_addr_d = row_addr_q + ADDR_W'(ROW_STEP);
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                    if (cnt_d == len_q) begin
                        idx_d   = '0;
                        state_d = RD_SET;
                    end
                end
            end
            RD_SET: state_d = RD_CAP;
            RD_CAP: state_d = RD_OUT;
            RD_OUT: begin
                if (res_fire) begin
                    if (idx_q != IDX_W'(NUM_OUT - 1)) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = RD_SET;
                    end else begin
                        idx_d   = '0;
                        state_d = clear_q ? CLEAR : IDLE;
                    end
                end
            end
            CLEAR: begin
                if (idx_q == IDX_W'(NUM_OUT - 1)) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Output values for the state being entered, so they are valid for its whole cycle.
        case (state_d)
            WRITE: begin
                drv_d.cs         = 1'b1;
                drv_d.write      = 1'b1;
                drv_d.address    = wr_addr;
                drv_d.input_data = wr_data;
            end
            COMPUTE, RD_OUT: drv_d.cs = 1'b1;
            RD_SET, RD_CAP: begin
                drv_d.cs         = 1'b1;
                drv_d.cim        = 1'b1;
                drv_d.output_reg = OREG_W'(idx_d);
            end
            CLEAR: begin
                drv_d.cs           = 1'b1;
                drv_d.cim          = 1'b1;
                drv_d.reset_output = 1'b1;
                drv_d.output_reg   = OREG_W'(idx_d);
            end
            default: drv_d = '0;
        endcase

        wr_ready_d  = (state_d == IDLE);
        job_ready_d = (state_d == IDLE);
        in_ready_d  = (state_d == COMPUTE);
        busy_d      = (state_d != IDLE);
        res_last_d  = (idx_d == IDX_W'(NUM_OUT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            row_addr_q <= '0;
            clear_q    <= 1'b0;
            drv_q      <= '0;
            wr_ready   <= 1'b1;
            job_ready  <= 1'b1;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            res_last   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            row_addr_q <= row_addr_d;
            clear_q    <= clear_d;
            drv_q      <= drv_d;
            wr_ready   <= wr_ready_d;
            job_ready  <= job_ready_d;
            in_ready   <= in_ready_d;
            busy       <= busy_d;
            res_last   <= res_last_d;
        end
    end

    // MAC strobe and its operands follow the input handshake within the same cycle.
    assign cim_cs           = drv_q.cs;
    assign cim_write        = drv_q.write;
    assign cim_cim          = drv_q.cim | in_fire;
    assign cim_partial_sum  = in_fire;
    assign cim_reset_output = drv_q.reset_output;
    assign cim_output_reg   = drv_q.output_reg;
    assign cim_address      = in_fire ? row_addr_q : drv_q.address;
    assign cim_input_data   = in_fire ? in_data : drv_q.input_data;
    assign cim_debug        = 1'b0;
    assign res_idx          = idx_q;

endmodule

// File: tb/tb_cim_ctrl.sv
// Directed bench for cim_ctrl: expected macro operations and results are queued per
// transaction and checked by a single negedge monitor.
module tb_cim_ctrl;
    import cim_pkg::*;

    localparam int K_WR  = 0;
    localparam int K_MAC = 1;
    localparam int K_RD  = 2;
    localparam int K_CLR = 3;

    typedef struct { int kind; logic [31:0] a; logic [31:0] d; } op_t;
    typedef struct { logic [31:0] d; logic [2:0] idx; logic last; } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid, wr_ready, job_valid, job_ready, job_clear;
    logic        in_valid, in_ready, res_valid, res_ready, res_last, busy;
    logic [31:0] wr_addr, wr_data, job_addr, in_data, res_data;
    logic [7:0]  job_len;
    logic [2:0]  res_idx;
    logic        cim_cs, cim_write, cim_cim, cim_partial_sum, cim_reset_output, cim_debug;
    logic [3:0]  cim_output_reg;
    logic [31:0] cim_address, cim_input_data, cim_result, cim_salt;

    op_t         exp_ops[$];
    res_t        exp_res[$];
    logic [31:0] mac_log[$];
    logic [3:0]  clr_reg_log[$];
    int          clr_cyc_log[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_res_seen, n_last_seen;

    // Macro readout model: each output register returns a job-specific fingerprint.
    assign cim_result = cim_salt + 32'(cim_output_reg) * 32'h0101_0101;

    always #5 clk = ~clk;

    cim_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .job_valid(job_valid), .job_ready(job_ready), .job_addr(job_addr),
        .job_len(job_len), .job_clear(job_clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_idx(res_idx), .res_last(res_last), .busy(busy),
        .cim_cs(cim_cs), .cim_write(cim_write), .cim_cim(cim_cim),
        .cim_partial_sum(cim_partial_sum), .cim_reset_output(cim_reset_output),
        .cim_output_reg(cim_output_reg), .cim_address(cim_address),
        .cim_input_data(cim_input_data), .cim_debug(cim_debug), .cim_result(cim_result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return wr_ready;
            1:       return job_ready;
            2:       return in_ready;
            3:       return res_valid;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_for(input int which, input string name);
        int t = 0;
        while (!sel(which) && t < 100) begin
            tick();
            t++;
        end
        if (!sel(which)) check({"timeout_", name}, 32'(sel(which)), 32'd1);
    endtask

    function automatic logic [31:0] word(input int k);
        return 32'h3333_3333 + 32'(k) * 32'h1111_1111;
    endfunction

    // Monitor: every cycle, classify the macro operation and compare with the expected stream.
    logic        hold_prev = 1'b0;
    logic [31:0] prev_data;
    logic [2:0]  prev_idx;
    logic        prev_last;

    always @(negedge clk) begin
        int  kind;
        op_t op;
        res_t r;
        cyc++;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            check("cim_debug", 32'(cim_debug), 32'd0);
            check("busy_vs_cs", 32'(busy), 32'(cim_cs));
            if (!cim_cs) begin
                check("idle_cim_zero", 32'(cim_write | cim_cim | cim_partial_sum | cim_reset_output
                      | (|cim_output_reg) | (|cim_address) | (|cim_input_data)), 32'd0);
            end else begin
                kind = cim_write ? K_WR : cim_partial_sum ? K_MAC :
                       cim_reset_output ? K_CLR : cim_cim ? K_RD : -1;
                if (kind < 0) begin
                    check("cs_only_zero", 32'((|cim_output_reg) | (|cim_address) | (|cim_input_data)), 32'd0);
                end else if (exp_ops.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_op: got kind %0d addr %h, expected none", kind, cim_address);
                end else begin
                    op = exp_ops.pop_front();
                    check("op_kind", 32'(kind), 32'(op.kind));
                    if (kind == K_WR || kind == K_MAC) begin
                        check("op_addr", cim_address, op.a);
                        check("op_data", cim_input_data, op.d);
                        if (kind == K_MAC) begin
                            check("mac_cim", 32'(cim_cim), 32'd1);
                            mac_log.push_back(cim_address);
                        end
                    end else begin
                        check("op_reg", 32'(cim_output_reg), op.a);
                        if (kind == K_CLR) begin
                            clr_reg_log.push_back(cim_output_reg);
                            clr_cyc_log.push_back(cyc);
                        end
                    end
                end
            end
            if (hold_prev) begin
                check("hold_data", res_data, prev_data);
                check("hold_idx", 32'(res_idx), 32'(prev_idx));
                check("hold_last", 32'(res_last), 32'(prev_last));
            end
            if (res_valid && res_ready) begin
                if (exp_res.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_res: got idx %0d data %h, expected none", res_idx, res_data);
                end else begin
                    r = exp_res.pop_front();
                    check("res_data", res_data, r.d);
                    check("res_idx", 32'(res_idx), 32'(r.idx));
                    check("res_last", 32'(res_last), 32'(r.last));
                end
                n_res_seen++;
                if (res_last) n_last_seen++;
            end
            hold_prev = res_valid && !res_ready;
            prev_data = res_data;
            prev_idx  = res_idx;
            prev_last = res_last;
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit with_job);
        exp_ops.push_back('{K_WR, a, d});
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        if (with_job) begin
            job_valid = 1'b1; job_addr = 32'h40; job_len = 8'd0; job_clear = 1'b0;
        end
        wait_for(0, "wr_ready");
        tick();
        wr_valid  = 1'b0;
        job_valid = 1'b0;
        check("wr_cim_write", 32'(cim_write), 32'd1);
        check("wr_cim_addr", cim_address, a);
        check("wr_cim_data", cim_input_data, d);
        check("wr_ready_after", 32'(wr_ready), 32'd0);
        tick();
        check("idle_after_write", 32'(busy), 32'd0);
    endtask

    task automatic run_job(input logic [31:0] a, input int len, input bit clr,
                           input logic [31:0] salt, input bit gaps, input int hold_idx);
        cim_salt = salt;
        mac_log.delete();
        clr_reg_log.delete();
        clr_cyc_log.delete();
        n_res_seen = 0;
        n_last_seen = 0;
        for (int k = 0; k < len; k++)
            exp_ops.push_back('{K_MAC, a + 32'(ROW_STEP * (k / ROW_WORDS)), word(k)});
        for (int i = 0; i < NUM_OUT; i++) begin
            exp_ops.push_back('{K_RD, 32'(i), 32'd0});
            exp_ops.push_back('{K_RD, 32'(i), 32'd0});
            exp_res.push_back('{salt + 32'(i) * 32'h0101_0101, 3'(i), i == NUM_OUT - 1});
        end
        if (clr)
            for (int i = 0; i < NUM_OUT; i++) exp_ops.push_back('{K_CLR, 32'(i), 32'd0});
        job_valid = 1'b1; job_addr = a; job_len = 8'(len); job_clear = clr;
        wait_for(1, "job_ready");
        tick();
        job_valid = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (gaps && (k % 2 == 1)) begin
                in_valid = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    check("gap_no_ps", 32'(cim_partial_sum), 32'd0);
                    check("gap_addr", cim_address, 32'd0);
                    tick();
                end
            end
            in_valid = 1'b1; in_data = word(k);
            wait_for(2, "in_ready");
            tick();
        end
        in_valid = 1'b0;
        for (int r = 0; r < NUM_OUT; r++) begin
            wait_for(3, "res_valid");
            if (r == hold_idx) begin
                repeat (5) begin
                    tick();
                    check("held_valid", 32'(res_valid), 32'd1);
                    check("held_idx", 32'(res_idx), 32'(hold_idx));
                end
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
        wait_for(4, "idle");
        check("ops_drained", 32'(exp_ops.size()), 32'd0);
        check("res_drained", 32'(exp_res.size()), 32'd0);
        check("res_count", 32'(n_res_seen), 32'd8);
        check("last_count", 32'(n_last_seen), 32'd1);
        check("mac_count", 32'(mac_log.size()), 32'(len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        wr_valid = 0; job_valid = 0; in_valid = 0; res_ready = 0; job_clear = 0;
        wr_addr = 0; wr_data = 0; job_addr = 0; job_len = 0; in_data = 0; cim_salt = 0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_cim_cs", 32'(cim_cs), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_wr_ready", 32'(wr_ready), 32'd1);
        check("idle_job_ready", 32'(job_ready), 32'd1);

        do_write(32'h0000_0000, 32'h3322_1100, 1'b0);
        do_write(32'h0000_0080, 32'h7766_5544, 1'b1);

        // Plain job with hold at idx 3 and accumulator clear.
        run_job(32'h0, 4, 1'b1, 32'hA000_0000, 1'b0, 3);
        if (mac_log.size() == 4) begin
            check("mac_addr0", mac_log[0], 32'h0);
            check("mac_addr1", mac_log[1], 32'h0);
            check("mac_addr2", mac_log[2], 32'h8);
            check("mac_addr3", mac_log[3], 32'h8);
        end
        check("clr_count", 32'(clr_reg_log.size()), 32'd8);
        for (int i = 0; i < clr_reg_log.size(); i++) begin
            check("clr_reg", 32'(clr_reg_log[i]), 32'(i));
            check("clr_consec", 32'(clr_cyc_log[i] - clr_cyc_log[0]), 32'(i));
        end

        // Same kind of job with input bubbles: addresses must only move on accepted words.
        run_job(32'h100, 5, 1'b0, 32'hB000_0000, 1'b1, -1);
        if (mac_log.size() == 5) begin
            check("gap_addr0", mac_log[0], 32'h100);
            check("gap_addr2", mac_log[2], 32'h108);
            check("gap_addr4", mac_log[4], 32'h110);
        end

        // Zero-length job goes straight to readout.
        run_job(32'h200, 0, 1'b0, 32'hC000_0005, 1'b0, -1);

        // Reset during COMPUTE: everything drops immediately, job is abandoned.
        cim_salt = 32'h0;
        exp_ops.push_back('{K_MAC, 32'h40, word(0)});
        exp_ops.push_back('{K_MAC, 32'h40, word(1)});
        job_valid = 1'b1; job_addr = 32'h40; job_len = 8'd4; job_clear = 1'b0;
        wait_for(1, "job_ready");
        tick();
        job_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = word(k);
            wait_for(2, "in_ready");
            tick();
        end
        in_valid = 1'b1; in_data = word(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cs", 32'(cim_cs), 32'd0);
        check("arst_ps", 32'(cim_partial_sum), 32'd0);
        check("arst_cim", 32'(cim_cim), 32'd0);
        check("arst_addr", cim_address, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        check("arst_ops_consumed", 32'(exp_ops.size()), 32'd0);
        exp_ops.delete();
        exp_res.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Next job after reset, starting near the top of the address space to wrap.
        run_job(32'hFFFF_FFF8, 4, 1'b0, 32'hD000_0000, 1'b0, -1);
        if (mac_log.size() == 4) begin
            check("wrap_addr1", mac_log[1], 32'hFFFF_FFF8);
            check("wrap_addr2", mac_log[2], 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
